// File: rtl/jt51_slot_pkg.sv
// rtl/jt51_slot_pkg.sv - shared constants and state encoding for the slot controller
package jt51_slot_pkg;

  localparam int STAGES = 32;
  localparam int SLOT_W = 5;

  localparam int CH_LSB = 0;
  localparam int CH_MSB = 2;
  localparam int OP_LSB = 3;
  localparam int OP_MSB = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } state_t;

endpackage

// File: rtl/jt51_slot_cnt.sv
// rtl/jt51_slot_cnt.sv - free-running slot counter with operator/channel decode
module jt51_slot_cnt
  import jt51_slot_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              cen,
  output logic [SLOT_W-1:0] slot,
  output logic [2:0]        ch,
  output logic [1:0]        op,
  output logic              zero
);

  logic [SLOT_W-1:0] cnt;

  // Five bits wrap 31 -> 0 on their own, matching the 32-deep ring.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (cen) begin
      cnt <= cnt + SLOT_W'(1);
    end
  end

  assign slot = cnt;
  assign ch   = cnt[CH_MSB:CH_LSB];
  assign op   = cnt[OP_MSB:OP_LSB];
  assign zero = (cnt == '0);

endmodule

// File: rtl/jt51_slot_ctrl.sv
// rtl/jt51_slot_ctrl.sv - single-entry write port into an external recirculating slot ring
module jt51_slot_ctrl
  import jt51_slot_pkg::*;
#(
  parameter int W      = 5,
  parameter int STAGES = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cen,
  input  logic              wr_valid,
  input  logic [SLOT_W-1:0] wr_slot,
  input  logic [W-1:0]      wr_data,
  output logic              wr_ready,
  output logic              wr_done,
  input  logic [W-1:0]      sh_drop,
  output logic [W-1:0]      sh_din,
  output logic [SLOT_W-1:0] slot,
  output logic [2:0]        ch,
  output logic [1:0]        op,
  output logic              zero
);

  generate
    if (STAGES != jt51_slot_pkg::STAGES) begin : g_bad_stages
      $error("jt51_slot_ctrl: only a 32-slot ring is supported");
    end
  endgenerate

  state_t            state;
  logic [SLOT_W-1:0] lat_slot;
  logic [W-1:0]      lat_data;
  logic              match;
  logic              commit;

  jt51_slot_cnt u_cnt (
    .clk  (clk),
    .rst  (rst),
    .cen  (cen),
    .slot (slot),
    .ch   (ch),
    .op   (op),
    .zero (zero)
  );

  assign match  = (state == ST_PEND) && (lat_slot == slot);
  assign commit = match && cen;

  // The pending value is only written on a cen edge; any other cycle keeps recirculating.
  assign sh_din = match ? lat_data : sh_drop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      lat_slot <= '0;
      lat_data <= '0;
      wr_ready <= 1'b1;
      wr_done  <= 1'b0;
    end else begin
      wr_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (wr_valid) begin
            lat_slot <= wr_slot;
            lat_data <= wr_data;
            wr_ready <= 1'b0;
            state    <= ST_PEND;
          end
        end
        ST_PEND: begin
          if (commit) begin
            wr_ready <= 1'b1;
            wr_done  <= 1'b1;
            state    <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jt51_slot_ctrl.sv
// tb/tb_jt51_slot_ctrl.sv - self-checking bench for jt51_slot_ctrl with an external 32-slot ring
module tb_jt51_slot_ctrl;

  localparam int W = 5;

  logic         clk = 1'b0;
  logic         rst;
  logic         cen;
  logic         wr_valid;
  logic [4:0]   wr_slot;
  logic [W-1:0] wr_data;
  logic         wr_ready;
  logic         wr_done;
  logic [W-1:0] sh_drop;
  logic [W-1:0] sh_din;
  logic [4:0]   slot;
  logic [2:0]   ch;
  logic [1:0]   op;
  logic         zero;

  always #5 clk = ~clk;

  jt51_slot_ctrl #(.W(W), .STAGES(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .cen      (cen),
    .wr_valid (wr_valid),
    .wr_slot  (wr_slot),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .wr_done  (wr_done),
    .sh_drop  (sh_drop),
    .sh_din   (sh_din),
    .slot     (slot),
    .ch       (ch),
    .op       (op),
    .zero     (zero)
  );

  // External ring; it is held while the controller is in reset.
  logic [W-1:0] ring [0:31];
  logic [W-1:0] seed [0:31];
  logic         ring_load;

  assign sh_drop = ring[31];

  always @(posedge clk) begin
    if (ring_load) begin
      for (int i = 0; i < 32; i++) ring[i] <= seed[i];
    end else if (cen && !rst) begin
      ring[0] <= sh_din;
      for (int i = 1; i < 32; i++) ring[i] <= ring[i-1];
    end
  end

  // Reference model: contents per slot index plus one pending transaction.
  int mem [32];
  int m_slot;
  bit m_pend;
  int m_tgt;
  int m_data;
  bit m_done;
  int m_commits;

  int ncmp;
  int nfail;
  int zero_cnt;
  int done_cnt;

  typedef struct {
    int tgt;
    int data;
    int acc;
    int lat;
  } vec_t;

  vec_t vec [6];

  task automatic chk(input string name, input int act, input int exp);
    ncmp++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic step(input bit r, input bit c, input bit v, input int s, input int d);
    int tmp [32];
    rst      = r;
    cen      = c;
    wr_valid = v;
    wr_slot  = 5'(s);
    wr_data  = W'(d);
    if (r) begin
      for (int j = 0; j < 32; j++) tmp[j] = mem[(m_slot + j) % 32];
      for (int j = 0; j < 32; j++) mem[j] = tmp[j];
      m_slot = 0;
      m_pend = 0;
      m_done = 0;
    end
    #2;
    chk("slot_pre", int'(slot), m_slot);
    chk("zero", int'(zero), int'(m_slot == 0));
    chk("ch", int'(ch), m_slot % 8);
    chk("op", int'(op), m_slot / 8);
    chk("wr_ready_pre", int'(wr_ready), int'(!m_pend));
    chk("wr_done_pre", int'(wr_done), int'(m_done));
    chk("sh_drop", int'(sh_drop), mem[m_slot]);
    chk("sh_din", int'(sh_din), (m_pend && m_tgt == m_slot) ? m_data : mem[m_slot]);
    if (zero) zero_cnt++;
    @(posedge clk);
    #1;
    if (!r) begin
      m_done = 0;
      if (m_pend && m_tgt == m_slot && c) begin
        m_pend = 0;
        mem[m_tgt] = m_data;
        m_done = 1;
        m_commits++;
      end else if (!m_pend && v) begin
        m_pend = 1;
        m_tgt  = s;
        m_data = d;
      end
      if (c) m_slot = (m_slot + 1) % 32;
    end
    chk("slot_post", int'(slot), m_slot);
    chk("wr_done", int'(wr_done), int'(m_done));
    chk("wr_ready", int'(wr_ready), int'(!m_pend));
    if (wr_done) done_cnt++;
  endtask

  task automatic spin_to(input int target);
    int n = 0;
    while (m_slot != target && n < 80) begin
      step(0, 1, 0, 0, 0);
      n++;
    end
    chk("spin_reach", m_slot, target);
  endtask

  initial begin
    int lat;
    bit seen;
    int dc;
    int mc;
    int old20;
    bit prev_done;

    rst = 1'b1; cen = 1'b0; wr_valid = 1'b0; wr_slot = '0; wr_data = '0;
    ring_load = 1'b1;
    ncmp = 0; nfail = 0; zero_cnt = 0; done_cnt = 0; m_commits = 0;
    m_slot = 0; m_pend = 0; m_tgt = 0; m_data = 0; m_done = 0;
    for (int j = 0; j < 32; j++) begin
      mem[j] = int'($urandom_range(0, 31));
      seed[31-j] = W'(mem[j]);
    end
    @(posedge clk);
    #1;
    ring_load = 1'b0;

    step(1, 0, 0, 0, 0);
    step(1, 1, 1, 7, 3);
    chk("rst_ready", int'(wr_ready), 1);
    chk("rst_zero", int'(zero), 1);
    chk("rst_slot", int'(slot), 0);

    // Two full turns of the counter after release.
    zero_cnt = 0;
    for (int k = 0; k < 64; k++) step(0, 1, 0, 0, 0);
    chk("zero_edges", zero_cnt, 2);

    vec[0] = '{tgt: 'h0B, data: 'h15, acc: 3,  lat: 8};
    vec[1] = '{tgt: 7,    data: 'h0A, acc: 8,  lat: 31};
    vec[2] = '{tgt: 5,    data: 'h1C, acc: 5,  lat: 32};
    vec[3] = '{tgt: 6,    data: 'h03, acc: 5,  lat: 1};
    vec[4] = '{tgt: 0,    data: 'h1F, acc: 31, lat: 1};
    vec[5] = '{tgt: 31,   data: 'h11, acc: 0,  lat: 31};

    for (int i = 0; i < 6; i++) begin
      spin_to(vec[i].acc);
      step(0, 1, 1, vec[i].tgt, vec[i].data);
      lat = 0;
      seen = 0;
      for (int k = 0; k < 40 && !seen; k++) begin
        step(0, 1, 0, 0, 0);
        lat++;
        if (wr_done) seen = 1;
      end
      chk($sformatf("latency_%0d", i), lat, vec[i].lat);
    end

    spin_to(11);
    chk("ring_slot11", int'(sh_drop), 'h15);

    // Match while cen is low must wait for a cen edge.
    spin_to(1);
    step(0, 1, 1, 2, 9);
    dc = done_cnt;
    for (int k = 0; k < 5; k++) step(0, 0, 0, 0, 0);
    chk("hold_no_done", done_cnt - dc, 0);
    chk("hold_pending", int'(wr_ready), 0);
    step(0, 1, 0, 0, 0);
    chk("hold_commit", int'(wr_done), 1);

    // Accepted at its own slot while the counter is still.
    spin_to(4);
    step(0, 0, 1, 4, 'h16);
    step(0, 1, 0, 0, 0);
    chk("same_slot_commit", int'(wr_done), 1);

    // Sparse cen with wr_valid held high.
    dc = done_cnt;
    mc = m_commits;
    prev_done = 0;
    for (int k = 0; k < 300; k++) begin
      step(0, (k % 3) == 0, 1, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)));
      if (prev_done) chk("reaccept", int'(wr_ready), 0);
      prev_done = wr_done;
    end
    chk("commits_sparse", done_cnt - dc, m_commits - mc);
    while (m_pend && m_slot < 200) step(0, 1, 0, 0, 0);

    // Reset while a write to slot 20 is pending at slot 15.
    spin_to(10);
    step(0, 1, 1, 20, (mem[20] + 1) % 32);
    spin_to(15);
    chk("pend_before_rst", int'(wr_ready), 0);
    old20 = mem[20];
    dc = done_cnt;
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    chk("rst_cnt_zero", int'(slot), 0);
    spin_to(5);
    chk("rst_no_done", done_cnt - dc, 0);
    chk("keep_old20", int'(sh_drop), old20);

    for (int k = 0; k < 3000; k++) begin
      step($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 7, $urandom_range(0, 3) == 0,
           int'($urandom_range(0, 31)), int'($urandom_range(0, 31)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/jt51_slot_ctrl.md
JT51_SLOT_CTRL -- requirements
Module: jt51_slot_ctrl

Interface
REQ-001 The module SHALL have parameter W, default 5, giving the data width of the controlled slot ring.
REQ-002 The module SHALL have parameter STAGES, default 32, giving the number of slots in the ring; only the value 32 is supported.
REQ-003 Port clk, input, 1 bit: clock for all state.
REQ-004 Port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 Port cen, input, 1 bit: clock enable; the ring and the slot counter advance only on clk edges with cen=1.
REQ-006 Port wr_valid, input, 1 bit: a write request is presented.
REQ-007 Port wr_slot, input, 5 bits: target slot, encoded as {op[1:0], ch[2:0]}.
REQ-008 Port wr_data, input, W bits: new value for the target slot.
REQ-009 Port wr_ready, output, 1 bit: the controller can accept a request.
REQ-010 Port wr_done, output, 1 bit: one-clk pulse when a pending write has been committed into the ring.
REQ-011 Port sh_drop, input, W bits: output of the external STAGES-deep shift ring.
REQ-012 Port sh_din, output, W bits: input of the external shift ring.
REQ-013 Port slot, output, 5 bits: index of the slot currently at sh_drop.
REQ-014 Port ch, output, 3 bits: equal to slot[2:0].
REQ-015 Port op, output, 2 bits: equal to slot[4:3].
REQ-016 Port zero, output, 1 bit: high while slot==0.

Function
REQ-017 The slot counter SHALL increment by 1 on each clk edge with cen=1, wrapping from 31 to 0; it SHALL hold its value when cen=0.
REQ-018 The outputs zero, ch and op SHALL be decoded directly from the registered counter, with no added latency.
REQ-019 The controller SHALL have two states: IDLE (wr_ready=1) and PEND (wr_ready=0).
REQ-020 In IDLE, when wr_valid=1, the controller SHALL latch wr_slot and wr_data on that clk edge and enter PEND, independent of cen.
REQ-021 While in PEND, wr_slot and wr_data SHALL be ignored.
REQ-022 sh_din SHALL equal the latched data when the state is PEND and the latched slot equals slot; otherwise sh_din SHALL equal sh_drop (recirculation).
REQ-023 A commit occurs on a clk edge where the state is PEND, the slot matches and cen=1; on that edge the state SHALL return to IDLE.
REQ-024 On the clk edge following a commit, wr_done SHALL be 1 for exactly one clk.
REQ-025 A match with cen=0 SHALL NOT commit; the request SHALL stay pending until a cen edge occurs at the matching slot.
REQ-026 A request accepted while its slot is already current SHALL commit at the next cen edge if the counter has not moved; otherwise it SHALL commit after the counter wraps back to that slot.
REQ-027 Commit latency SHALL be at most STAGES cen edges after acceptance.
REQ-028 On the commit edge wr_ready SHALL be 0; a new request SHALL be accepted no earlier than the following clk edge.
REQ-029 The controller SHALL hold at most one outstanding request.

Reset
REQ-030 While rst=1, the slot counter SHALL be 0, the state SHALL be IDLE, the latched slot and data SHALL be 0, wr_done SHALL be 0, wr_ready SHALL be 1 and zero SHALL be 1.
REQ-031 Asserting rst while in PEND SHALL discard the pending request without asserting wr_done.
REQ-032 During reset, sh_din SHALL equal sh_drop.

Structure
REQ-033 The shared package jt51_slot_pkg SHALL hold STAGES=32, the slot width of 5, the CH and OP field positions, and the IDLE/PEND state encoding.
REQ-034 The slot counter and its decode (slot, ch, op, zero) SHALL be the single sub-module jt51_slot_cnt.
REQ-035 The shift ring SHALL stay outside this module.

Verification
REQ-036 Reset release followed by cen held at 1 for 64 clks: slot SHALL count 0..31 twice, and zero SHALL be high on exactly 2 of those edges.
REQ-037 A write of slot=5'h0B, data=5'h15 accepted at slot 3: sh_din SHALL be 5'h15 exactly at slot 11, wr_done SHALL pulse once on the following clk, and after one full ring turn sh_drop at slot 11 SHALL be 5'h15.
REQ-038 A write of slot=7 accepted at slot 8: the commit SHALL occur 31 cen edges later, and all other slots SHALL recirculate unchanged.
REQ-039 cen toggling every 3rd clk with wr_valid held at 1: wr_ready SHALL drop for the whole pending time, only the first request SHALL be taken, and the next request SHALL be accepted the clk after wr_done.
REQ-040 rst asserted while a write to slot 20 is pending at slot 15: there SHALL be no wr_done, the counter SHALL be 0, and after release slot 20 SHALL keep its old ring value.
